write_back_unit: RTL

WRITE_BACK_UNIT -- requirements
Module: write_back_unit

---
 rtl/write_back_unit_if.sv | 35 +++
 rtl/write_back_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/write_back_unit_if.sv
// Handshake and register-file write bundle for write_back_unit.
// master = pipeline/memory side driving the unit, slave = the unit itself.
interface write_back_unit_if #(
   parameter int WIDTH = 32
);
   logic              freeze;
   logic              In_Valid;
   logic              In_Ready;
   logic              In_WB_EN;
   logic              In_MEM_R_EN;
   logic [3:0]        In_Dest;
   logic [WIDTH-1:0]  In_ALU_Res;
   logic [WIDTH-1:0]  In_Mem_Data;
   logic              Blk_EN;
   logic [14:0]       In_Reg_List;
   logic              Beat_Valid;
   logic [WIDTH-1:0]  Beat_Data;
   logic              Beat_Ready;
   logic              WB_WB_EN;
   logic [3:0]        WB_Dest;
   logic [WIDTH-1:0]  WB_Value;
   logic              Blk_Done;

   modport master (
      output freeze, In_Valid, In_WB_EN, In_MEM_R_EN, In_Dest, In_ALU_Res, In_Mem_Data,
             Blk_EN, In_Reg_List, Beat_Valid, Beat_Data,
      input  In_Ready, Beat_Ready, WB_WB_EN, WB_Dest, WB_Value, Blk_Done
   );

   modport slave (
      input  freeze, In_Valid, In_WB_EN, In_MEM_R_EN, In_Dest, In_ALU_Res, In_Mem_Data,
             Blk_EN, In_Reg_List, Beat_Valid, Beat_Data,
      output In_Ready, Beat_Ready, WB_WB_EN, WB_Dest, WB_Value, Blk_Done
   );
endinterface

// File: rtl/write_back_unit.sv
// Write-back stage: single register writes plus an optional block-load sequencer
// that is compiled in only when WB_BLOCK_XFER_EN is defined.
module write_back_unit #(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   write_back_unit_if.slave    bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BLOCK = 1'b1
   } state_t;

   state_t            state_r;
   logic              wb_en_r;
   logic [3:0]        wb_dest_r;
   logic [WIDTH-1:0]  wb_value_r;
   logic              blk_done_r;

   logic              in_ready_s;
   logic              beat_ready_s;
   logic              accept_s;
   logic              blk_accept_s;
   logic              single_write_s;
   logic [WIDTH-1:0]  single_value_s;

`ifdef WB_BLOCK_XFER_EN
   logic [14:0]       mask_r;
   logic              beat_s;
   logic [3:0]        beat_dest_s;
   logic [14:0]       mask_next_s;

   // Index of the lowest set bit: block registers are filled in ascending order.
   function automatic logic [3:0] lowest_set(input logic [14:0] m);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 14; i >= 0; i--) begin
         if (m[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction
`else
   logic              unused_s;
   assign unused_s = ^{bus.Blk_EN, bus.In_Reg_List, bus.Beat_Valid, bus.Beat_Data};
`endif

   // Handshake readiness and per-cycle write decode.
   always_comb begin
      in_ready_s     = (state_r == IDLE) && !bus.freeze;
      accept_s       = bus.In_Valid && in_ready_s;
      single_value_s = bus.In_MEM_R_EN ? bus.In_Mem_Data : bus.In_ALU_Res;
`ifdef WB_BLOCK_XFER_EN
      beat_ready_s   = (state_r == BLOCK) && !bus.freeze;
      blk_accept_s   = accept_s && bus.Blk_EN;
      beat_s         = bus.Beat_Valid && beat_ready_s;
      beat_dest_s    = lowest_set(mask_r);
      mask_next_s    = mask_r & (mask_r - 15'd1);
`else
      beat_ready_s   = 1'b0;
      blk_accept_s   = 1'b0;
`endif
      // R15 is the PC, not a register-file entry, so it never gets a write strobe.
      single_write_s = accept_s && !blk_accept_s && bus.In_WB_EN && (bus.In_Dest != 4'd15);
   end

   // Control FSM and registered register-file write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         wb_en_r    <= 1'b0;
         wb_dest_r  <= 4'd0;
         wb_value_r <= {WIDTH{1'b0}};
         blk_done_r <= 1'b0;
`ifdef WB_BLOCK_XFER_EN
         mask_r     <= 15'd0;
`endif
      end else begin
         wb_en_r    <= 1'b0;
         blk_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (single_write_s) begin
                  wb_en_r    <= 1'b1;
                  wb_dest_r  <= bus.In_Dest;
                  wb_value_r <= single_value_s;
               end else if (blk_accept_s) begin
`ifdef WB_BLOCK_XFER_EN
                  // An empty list has nothing to load; report completion right away.
                  if (bus.In_Reg_List != 15'd0) begin
                     mask_r  <= bus.In_Reg_List;
                     state_r <= BLOCK;
                  end else begin
                     blk_done_r <= 1'b1;
                  end
`else
                  state_r <= IDLE;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            BLOCK: begin
`ifdef WB_BLOCK_XFER_EN
               if (beat_s) begin
                  wb_en_r    <= 1'b1;
                  wb_dest_r  <= beat_dest_s;
                  wb_value_r <= bus.Beat_Data;
                  mask_r     <= mask_next_s;
                  if (mask_next_s == 15'd0) begin
                     blk_done_r <= 1'b1;
                     state_r    <= IDLE;
                  end else begin
                     state_r <= BLOCK;
                  end
               end else begin
                  state_r <= BLOCK;
               end
`else
               state_r <= IDLE;
`endif
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.In_Ready   = in_ready_s;
   assign bus.Beat_Ready = beat_ready_s;
   assign bus.WB_WB_EN   = wb_en_r;
   assign bus.WB_Dest    = wb_dest_r;
   assign bus.WB_Value   = wb_value_r;
   assign bus.Blk_Done   = blk_done_r;

endmodule
